// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used with the Uart8 receiver and its FIFO.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned CLOCK_RATE  = 12_000_000;
  localparam int unsigned BAUD        = 9600;
  localparam int unsigned ERR_CNT_W   = 8;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int unsigned countWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the receive FIFO and its neighbours: Uart8 capture side and host pop side.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = UART_DATA_W,
  parameter int unsigned DEPTH = 16
) ();

  localparam int unsigned CNT_W = countWidth(DEPTH);

  logic                 rxDone;
  logic                 rxErr;
  logic [WIDTH-1:0]     rxOut;
  logic                 rdEn;
  logic                 ovfClr;
  logic [WIDTH-1:0]     rdData;
  logic                 empty;
  logic                 full;
  logic [CNT_W-1:0]     count;
  logic                 overflow;
  logic [ERR_CNT_W-1:0] errCount;

  // Drives the FIFO (receiver plus host logic)
  modport master (
    output rxDone, rxErr, rxOut, rdEn, ovfClr,
    input  rdData, empty, full, count, overflow, errCount
  );

  // The FIFO itself
  modport slave (
    input  rxDone, rxErr, rxOut, rdEn, ovfClr,
    output rdData, empty, full, count, overflow, errCount
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read (LUT RAM friendly).
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [WIDTH-1:0]         wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [WIDTH-1:0]         rdData_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData_c = mem[rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind Uart8: edge-detected capture, frame-error drop,
// sticky overflow flag. Optional error counter enabled by UART_RX_FIFO_ERRCNT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = UART_DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = countWidth(DEPTH);

  logic                 rxDonePrev;
  logic [ADDR_W-1:0]    wrPtr;
  logic [ADDR_W-1:0]    rdPtr;
  logic [CNT_W-1:0]     count;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic [WIDTH-1:0]     rdData;
  logic [ERR_CNT_W-1:0] errCnt;

  logic                 pushStrobe;
  logic                 doPush;
  logic                 doPop;
  logic                 doDrop;
  logic [ADDR_W-1:0]    wrPtrNext;
  logic [ADDR_W-1:0]    rdPtrNext;
  logic [CNT_W-1:0]     countNext;
  logic [WIDTH-1:0]     memRd;
  logic [WIDTH-1:0]     headNext;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uMem (
    .clk      (clk),
    .wrEn     (doPush),
    .wrAddr   (wrPtr),
    .wrData   (bus.rxOut),
    .rdAddr   (rdPtrNext),
    .rdData_c (memRd)
  );

  // Push/pop decisions, next pointers and next head word (bypass when the new byte becomes head)
  always_comb begin
    pushStrobe = bus.rxDone & ~rxDonePrev;
    doPop      = bus.rdEn & ~empty;
    doPush     = pushStrobe & ~bus.rxErr & (~full | doPop);
    doDrop     = pushStrobe & ~bus.rxErr & full & ~doPop;
    wrPtrNext  = doPush ? wrPtr + ADDR_W'(1) : wrPtr;
    rdPtrNext  = doPop  ? rdPtr + ADDR_W'(1) : rdPtr;
    countNext  = count + CNT_W'(doPush) - CNT_W'(doPop);
    headNext   = '0;
    if (countNext != '0) begin
      headNext = (doPush && (wrPtr == rdPtrNext)) ? bus.rxOut : memRd;
    end
  end

  // Pointers, occupancy, flags and registered head word
  always_ff @(posedge clk) begin
    if (reset) begin
      rxDonePrev <= 1'b1;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      rdData     <= '0;
    end else begin
      rxDonePrev <= bus.rxDone;
      wrPtr      <= wrPtrNext;
      rdPtr      <= rdPtrNext;
      count      <= countNext;
      empty      <= (countNext == '0);
      full       <= (countNext == CNT_W'(DEPTH));
      rdData     <= headNext;
      if (doDrop) begin
        overflow <= 1'b1;
      end else if (bus.ovfClr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_ERRCNT_EN
  // Saturating count of frame-error bytes discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      errCnt <= '0;
    end else if (pushStrobe && bus.rxErr && (errCnt != {ERR_CNT_W{1'b1}})) begin
      errCnt <= errCnt + ERR_CNT_W'(1);
    end
  end
`else
  assign errCnt = '0;
`endif

  assign bus.rdData   = rdData;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.errCount = errCnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued on push, compared on pop.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] sbQ[$];
  logic             expOvf;
  int               expErr;
  int               nChecks;
  int               nFails;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    checkEq({tag, ".count"},    32'(bus.count),    32'(sbQ.size()));
    checkEq({tag, ".empty"},    32'(bus.empty),    32'(sbQ.size() == 0));
    checkEq({tag, ".full"},     32'(bus.full),     32'(sbQ.size() == DEPTH));
    checkEq({tag, ".overflow"}, 32'(bus.overflow), 32'(expOvf));
    checkEq({tag, ".errCount"}, 32'(bus.errCount), 32'(expErr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelErr();
`ifdef UART_RX_FIFO_ERRCNT_EN
    if (expErr < 255) expErr++;
`endif
  endfunction

  task automatic pushByte(input logic [7:0] data, input logic err, input logic clr);
    bus.rxDone = 1'b1;
    bus.rxOut  = data;
    bus.rxErr  = err;
    bus.ovfClr = clr;
    step();
    bus.rxDone = 1'b0;
    bus.rxErr  = 1'b0;
    bus.ovfClr = 1'b0;
    if (err) modelErr();
    else if (sbQ.size() < DEPTH) sbQ.push_back(data);
    else expOvf = 1'b1;
    if (clr && !(!err && sbQ.size() == DEPTH && expOvf)) expOvf = expOvf & ~clr;
    step();
  endtask

  task automatic popByte(input string tag);
    if (sbQ.size() > 0) checkEq({tag, ".rdData"}, 32'(bus.rdData), 32'(sbQ[0]));
    bus.rdEn = 1'b1;
    step();
    bus.rdEn = 1'b0;
    if (sbQ.size() > 0) void'(sbQ.pop_front());
  endtask

  task automatic pushPop(input string tag, input logic [7:0] data);
    if (sbQ.size() > 0) checkEq({tag, ".rdData"}, 32'(bus.rdData), 32'(sbQ[0]));
    bus.rdEn   = 1'b1;
    bus.rxDone = 1'b1;
    bus.rxOut  = data;
    step();
    bus.rdEn   = 1'b0;
    bus.rxDone = 1'b0;
    if (sbQ.size() > 0) void'(sbQ.pop_front());
    sbQ.push_back(data);
    step();
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    step();
    sbQ.delete();
    expOvf = 1'b0;
    expErr = 0;
    checkState(tag);
    checkEq({tag, ".rdData"}, 32'(bus.rdData), 32'h0);
    reset = 1'b0;
    step();
  endtask

  initial begin
    nChecks    = 0;
    nFails     = 0;
    expOvf     = 1'b0;
    expErr     = 0;
    reset      = 1'b1;
    bus.rxDone = 1'b0;
    bus.rxErr  = 1'b0;
    bus.rxOut  = '0;
    bus.rdEn   = 1'b0;
    bus.ovfClr = 1'b0;
    step();
    doReset("reset");

    // Single byte in, single byte out
    pushByte(8'h56, 1'b0, 1'b0);
    checkState("t1.push");
    checkEq("t1.rdData", 32'(bus.rdData), 32'h56);
    popByte("t1.pop");
    checkState("t1.afterPop");

    // Fill, overflow, clear, set-wins-over-clear, then drain in order
    for (int i = 0; i < 16; i++) pushByte(8'(i), 1'b0, 1'b0);
    checkState("t2.full");
    pushByte(8'hAA, 1'b0, 1'b0);
    checkState("t2.ovf");
    bus.ovfClr = 1'b1;
    step();
    bus.ovfClr = 1'b0;
    expOvf = 1'b0;
    checkState("t2.clr");
    pushByte(8'hBB, 1'b0, 1'b1);
    checkState("t2.setWins");
    bus.ovfClr = 1'b1;
    step();
    bus.ovfClr = 1'b0;
    expOvf = 1'b0;
    for (int i = 0; i < 16; i++) popByte("t2.drain");
    checkState("t2.empty");

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) pushByte(8'(8'h60 + i), 1'b0, 1'b0);
    pushPop("t3.pp", 8'h77);
    checkState("t3.afterPP");
    for (int i = 0; i < 16; i++) popByte("t3.drain");
    checkState("t3.empty");

    // Push and pop together on an empty FIFO: the pop is ignored
    pushPop("t3.ppEmpty", 8'h42);
    checkState("t3.ppEmpty");
    popByte("t3.ppEmptyPop");

    // Long rxDone level gives one entry; rxDone held through reset release gives none
    bus.rxDone = 1'b1;
    bus.rxOut  = 8'h31;
    repeat (5) step();
    bus.rxDone = 1'b0;
    sbQ.push_back(8'h31);
    step();
    checkState("t4.level");
    popByte("t4.pop");
    bus.rxDone = 1'b1;
    bus.rxOut  = 8'h32;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
    bus.rxDone = 1'b0;
    step();
    sbQ.delete();
    expOvf = 1'b0;
    expErr = 0;
    checkState("t4.resetHeld");

    // Frame-error bytes are dropped, including while full
    pushByte(8'h11, 1'b0, 1'b0);
    pushByte(8'h99, 1'b1, 1'b0);
    checkState("t5.err");
    for (int i = 0; i < 15; i++) pushByte(8'(8'h20 + i), 1'b0, 1'b0);
    pushByte(8'h98, 1'b1, 1'b0);
    checkState("t5.errFull");
    for (int i = 0; i < 16; i++) popByte("t5.drain");

    // Pointer wrap-around
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) pushByte(8'(8'h80 + r * 10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) popByte("t6.wrap");
    end
    checkState("t6.wrapEnd");

    // Reset with data queued
    for (int i = 0; i < 5; i++) pushByte(8'(8'hC0 + i), 1'b0, 1'b0);
    checkState("t6.queued");
    doReset("t6.reset");

    // Random mix against the scoreboard
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: pushByte(8'($urandom), 1'b0, 1'b0);
        1: popByte("rnd.pop");
        2: pushPop("rnd.pp", 8'($urandom));
        default: pushByte(8'($urandom), 1'b1, 1'b0);
      endcase
      checkState("rnd");
      if (expOvf && ($urandom_range(0, 3) == 0)) begin
        bus.ovfClr = 1'b1;
        step();
        bus.ovfClr = 1'b0;
        expOvf = 1'b0;
      end
    end
    while (sbQ.size() > 0) popByte("rnd.drain");
    checkState("rnd.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
